// File: rtl/wide_add_pkg.sv
// Shared types and default sizing for the chunked wide adder.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CHUNK_W_DEF = 10;
  localparam int CHUNKS_DEF  = 4;

endpackage

// File: rtl/add_slice.sv
// Narrow combinational adder slice; the controller time-multiplexes it across chunks.
module add_slice #(
  parameter int CHUNK_W = 10
) (
  input  logic [CHUNK_W-1:0] x,
  input  logic [CHUNK_W-1:0] y,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s,
  output logic               co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK_W{1'b0}}, ci};

endmodule

// File: rtl/wide_add_seq.sv
// Wide adder built by stepping one CHUNK_W-bit slice over CHUNKS chunks, with valid/ready on both sides.
// Define WIDE_ADD_SUB_EN to add the sub input (a-b) and the signed-overflow output ovf.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int CHUNKS  = CHUNKS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHUNK_W*CHUNKS-1:0]   a,
  input  logic [CHUNK_W*CHUNKS-1:0]   b,
  input  logic                        cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                        sub,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHUNK_W*CHUNKS-1:0]   sum,
  output logic                        cout
`ifdef WIDE_ADD_SUB_EN
  ,
  output logic                        ovf
`endif
);

  localparam int N     = CHUNK_W * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_t             state;
  logic [N-1:0]       a_r;
  logic [N-1:0]       b_r;
  logic [N-1:0]       sum_r;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        base;
  logic [CHUNK_W-1:0] slice_x;
  logic [CHUNK_W-1:0] slice_y;
  logic [CHUNK_W-1:0] slice_s;
  logic               slice_co;
`ifdef WIDE_ADD_SUB_EN
  logic               ovf_r;
`endif

  // The current chunk of both operands is routed into the single shared slice.
  assign base    = 32'(idx) * 32'(CHUNK_W);
  assign slice_x = a_r[base +: CHUNK_W];
  assign slice_y = b_r[base +: CHUNK_W];

  add_slice #(.CHUNK_W(CHUNK_W)) u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
`ifdef WIDE_ADD_SUB_EN
            ovf_r      <= 1'b0;
            // Subtraction is a + ~b + 1, so cin is deliberately ignored here.
            if (sub) begin
              b_r   <= ~b;
              carry <= 1'b1;
            end else begin
              b_r   <= b;
              carry <= cin;
            end
`else
            b_r        <= b;
            carry      <= cin;
`endif
          end
        end
        RUN: begin
          sum_r[base +: CHUNK_W] <= slice_s;
          carry                  <= slice_co;
          if (idx == LAST_IDX) begin
            idx         <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
`ifdef WIDE_ADD_SUB_EN
            // The top sum bit is only known this cycle, so use the slice output directly.
            ovf_r <= (a_r[N-1] == b_r[N-1]) && (slice_s[CHUNK_W-1] != a_r[N-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = carry;
`ifdef WIDE_ADD_SUB_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (default 10x4 = 40-bit); sub/ovf cases build with WIDE_ADD_SUB_EN.
module tb_wide_add_seq;
  import wide_add_pkg::*;

  localparam int N = CHUNK_W_DEF * CHUNKS_DEF;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
`ifdef WIDE_ADD_SUB_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  wide_add_seq #(.CHUNK_W(CHUNK_W_DEF), .CHUNKS(CHUNKS_DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef WIDE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef WIDE_ADD_SUB_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain unsigned and signed arithmetic on the operands.
  function automatic logic [N+1:0] refModel(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input logic c, input logic s);
    logic [N:0] t;
    longint     sx, sy, r;
    logic       ov;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      t = {1'b0, x} + {1'b0, ~y} + 41'd1;
      r = sx - sy;
    end else begin
      t = {1'b0, x} + {1'b0, y} + {40'd0, c};
      r = sx + sy + longint'(c);
    end
    ov = (r > 64'sd549755813887) || (r < -64'sd549755813888);
    return {ov, t};
  endfunction

  function automatic logic [N-1:0] rand40();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return {1'b0, {(N-1){1'b1}}};
      default: return r[N-1:0];
    endcase
  endfunction

  // Present one operation and hold it for the accept edge, then scramble the operand pins.
  task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y, input logic c, input logic s);
    @(negedge clk);
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = rand40();
    b        = rand40();
    cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) return;
    end
    checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("valid_drops_after_consume", 64'(out_valid), 64'd0);
    checkOutput("ready_after_consume", 64'(in_ready), 64'd1);
  endtask

  task automatic checkResult(input string tag, input logic [N+1:0] exp);
    checkOutput({tag, "_sum"}, 64'(sum), 64'(exp[N-1:0]));
    checkOutput({tag, "_cout"}, 64'(cout), 64'(exp[N]));
`ifdef WIDE_ADD_SUB_EN
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(exp[N+1]));
`endif
  endtask

  initial begin
    int           lat;
    int           results;
    int           budget;
    logic [N-1:0] x, y;
    logic         c, s;
    logic [N+1:0] exp;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_sum", 64'(sum), 64'd0);
    checkOutput("reset_cout", 64'(cout), 64'd0);
    rst = 1'b0;

    // All-ones plus one wraps to zero with carry out, and shows the latency.
    applyStimulus(40'hFF_FFFF_FFFF, 40'h1, 1'b0, 1'b0);
    waitValid(lat);
    checkOutput("t1_latency", 64'(lat), 64'd4);
    checkOutput("t1_sum", 64'(sum), 64'h0);
    checkOutput("t1_cout", 64'(cout), 64'd1);
    consume();

    applyStimulus(40'h12_3456_789A, 40'h01_0101_0101, 1'b1, 1'b0);
    waitValid(lat);
    checkOutput("t2_latency", 64'(lat), 64'd4);
    checkOutput("t2_sum", 64'(sum), 64'h13_3557_799C);
    checkOutput("t2_cout", 64'(cout), 64'd0);
    consume();

    // Busy-time request is ignored and a stalled result stays stable.
    x = 40'hAB_CDEF_0123; y = 40'h98_7654_3210;
    exp = refModel(x, y, 1'b0, 1'b0);
    applyStimulus(x, y, 1'b0, 1'b0);
    @(negedge clk);
    a = 40'h1; b = 40'h1; cin = 1'b0; in_valid = 1'b1;
    checkOutput("t3_ready_run", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitValid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t3_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("t3_hold_ready", 64'(in_ready), 64'd0);
      checkOutput("t3_hold_sum", 64'(sum), 64'(exp[N-1:0]));
    end
    checkResult("t3", exp);
    consume();
    repeat (8) @(negedge clk);
    checkOutput("t3_no_ghost_result", 64'(out_valid), 64'd0);

    // Reset in the second RUN cycle clears everything.
    applyStimulus(40'hF0_F0F0_F0F0, 40'h0F_0F0F_0F0F, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t4_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t4_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t4_rst_sum", 64'(sum), 64'd0);
    checkOutput("t4_rst_cout", 64'(cout), 64'd0);
`ifdef WIDE_ADD_SUB_EN
    checkOutput("t4_rst_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    applyStimulus(40'd5, 40'd7, 1'b0, 1'b0);
    waitValid(lat);
    checkOutput("t4_sum", 64'(sum), 64'd12);
    checkOutput("t4_cout", 64'(cout), 64'd0);
    consume();

`ifdef WIDE_ADD_SUB_EN
    applyStimulus(40'd3, 40'd5, 1'b1, 1'b1);
    waitValid(lat);
    checkOutput("t5_sum", 64'(sum), 64'hFF_FFFF_FFFE);
    checkOutput("t5_cout", 64'(cout), 64'd0);
    checkOutput("t5_ovf", 64'(ovf), 64'd0);
    consume();
    applyStimulus(40'h7F_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b0, 1'b1);
    waitValid(lat);
    checkOutput("t6_sum", 64'(sum), 64'h80_0000_0000);
    checkOutput("t6_ovf", 64'(ovf), 64'd1);
    consume();
`endif

    // Random operations with random consumer stalls.
    results = 0;
    for (int n = 0; n < 100; n++) begin
      x = rand40();
      y = rand40();
      c = 1'($urandom_range(0, 1));
`ifdef WIDE_ADD_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      exp = refModel(x, y, c, s);
      applyStimulus(x, y, c, s);
      budget = 0;
      while (budget < 60) begin
        @(negedge clk);
        budget++;
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          checkResult("rand", exp);
          @(posedge clk);
          #1;
          out_ready = 1'b0;
          results++;
          @(negedge clk);
          checkOutput("rand_valid_drops", 64'(out_valid), 64'd0);
          break;
        end
      end
      if (budget >= 60) checkOutput("rand_timeout", 64'(budget), 64'd0);
    end
    checkOutput("rand_result_count", 64'(results), 64'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
